// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : shared types and op decode for the counter bank
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_LOAD = 2'd3
  } cnt_op_e;

  // Load wins; simultaneous up and down cancel to a hold.
  function automatic cnt_op_e decode_op(input logic load, input logic incr, input logic decr);
    cnt_op_e op;
    if (load)             op = OP_LOAD;
    else if (incr && decr) op = OP_HOLD;
    else if (incr)        op = OP_UP;
    else if (decr)        op = OP_DOWN;
    else                  op = OP_HOLD;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_channel.sv
// ============================================================================
// counter_channel : one up/down counter with terminal value, tc pulse, sticky ovf
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_channel
  import counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         incr,
  input  logic         decr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic [N-1:0] max,
  input  cnt_mode_e    mode,
  input  logic         clr_ovf,
  output logic [N-1:0] count,
  output logic         tc,
  output logic         ovf
);

  logic [N-1:0] r_count;
  logic         r_tc;
  logic         r_ovf;
  logic [N-1:0] w_next;
  logic         w_bnd;
  cnt_op_e      w_op;

  assign w_op = decode_op(load, incr, decr);

  always_comb begin
    w_next = r_count;
    w_bnd  = 1'b0;
    case (w_op)
      OP_LOAD: w_next = (load_val > max) ? max : load_val;
      // >= so a max lowered beneath the count still yields a boundary event
      OP_UP: begin
        if (r_count < max) begin
          w_next = r_count + 1'b1;
        end else begin
          w_bnd  = 1'b1;
          w_next = (mode == CNT_SAT) ? max : '0;
        end
      end
      OP_DOWN: begin
        if (r_count != '0) begin
          w_next = r_count - 1'b1;
        end else begin
          w_bnd  = 1'b1;
          w_next = (mode == CNT_SAT) ? '0 : max;
        end
      end
      default: w_next = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tc    <= w_bnd;
      if (w_bnd)        r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire

// File: rtl/counter_bank.sv
// ============================================================================
// counter_bank : CH independent up/down counters sharing one wrap/sat mode
// Rev 1.0
// ============================================================================
`default_nettype none

module counter_bank
  import counter_pkg::*;
#(
  parameter int N  = 8,
  parameter int CH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        incr,
  input  logic [CH-1:0]        decr,
  input  logic [CH-1:0]        load,
  input  logic [CH-1:0][N-1:0] load_val,
  input  logic [CH-1:0][N-1:0] max,
  input  logic                 sat,
  input  logic [CH-1:0]        clr_ovf,
  output logic [CH-1:0][N-1:0] count,
  output logic [CH-1:0]        tc,
  output logic [CH-1:0]        ovf
);

  cnt_mode_e w_mode;
  assign w_mode = sat ? CNT_SAT : CNT_WRAP;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    counter_channel #(.N(N)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .incr     (incr[g]),
      .decr     (decr[g]),
      .load     (load[g]),
      .load_val (load_val[g]),
      .max      (max[g]),
      .mode     (w_mode),
      .clr_ovf  (clr_ovf[g]),
      .count    (count[g]),
      .tc       (tc[g]),
      .ovf      (ovf[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_bank.sv
// ============================================================================
// tb_counter_bank : directed self-checking bench for counter_bank (N=8, CH=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_counter_bank;

  localparam int N  = 8;
  localparam int CH = 4;

  logic                 clk;
  logic                 rst;
  logic [CH-1:0]        incr;
  logic [CH-1:0]        decr;
  logic [CH-1:0]        load;
  logic [CH-1:0][N-1:0] load_val;
  logic [CH-1:0][N-1:0] max;
  logic                 sat;
  logic [CH-1:0]        clr_ovf;
  logic [CH-1:0][N-1:0] count;
  logic [CH-1:0]        tc;
  logic [CH-1:0]        ovf;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  counter_bank #(.N(N), .CH(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .incr     (incr),
    .decr     (decr),
    .load     (load),
    .load_val (load_val),
    .max      (max),
    .sat      (sat),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; incr = '0; decr = '0; load = '0; clr_ovf = '0; sat = 1'b0;
    load_val = '0;
    for (int i = 0; i < CH; i++) max[i] = 8'd255;
    step();
    chk_cnt++; if (count !== '0) $display("FAIL reset_count: got %h want 0", count); else pass_cnt++;
    chk_cnt++; if (tc !== '0)    $display("FAIL reset_tc: got %b want 0", tc);      else pass_cnt++;
    chk_cnt++; if (ovf !== '0)   $display("FAIL reset_ovf: got %b want 0", ovf);    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_incr();
    chk_cnt++; if (count[0] !== 8'd0) $display("FAIL incr_start: got %0d want 0", count[0]); else pass_cnt++;
    incr[0] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_cnt++;
      if (count[0] !== 8'(i)) $display("FAIL incr_ch0 step%0d: got %0d want %0d", i, count[0], i);
      else pass_cnt++;
    end
    incr[0] = 1'b0;
    chk_cnt++; if (count[3:1] !== '0) $display("FAIL incr_others: got %h want 0", count[3:1]); else pass_cnt++;
    chk_cnt++; if (tc !== '0)  $display("FAIL incr_tc: got %b want 0", tc);   else pass_cnt++;
    chk_cnt++; if (ovf !== '0) $display("FAIL incr_ovf: got %b want 0", ovf); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_c [5];
    logic         exp_t [5];
    exp_c = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    max[1] = 8'd3; sat = 1'b0; incr[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_cnt++;
      if (count[1] !== exp_c[i]) $display("FAIL wrap_count step%0d: got %0d want %0d", i, count[1], exp_c[i]);
      else pass_cnt++;
      chk_cnt++;
      if (tc[1] !== exp_t[i]) $display("FAIL wrap_tc step%0d: got %b want %b", i, tc[1], exp_t[i]);
      else pass_cnt++;
    end
    incr[1] = 1'b0;
    chk_cnt++; if (ovf[1] !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", ovf[1]); else pass_cnt++;
  endtask

  task automatic test_sat_down();
    logic [N-1:0] exp_c [4];
    logic         exp_t [4];
    exp_c = '{8'd2, 8'd1, 8'd0, 8'd0};
    exp_t = '{1'b0, 1'b0, 1'b0, 1'b1};
    max[2] = 8'd3; sat = 1'b1; load[2] = 1'b1; load_val[2] = 8'd3;
    step();
    load[2] = 1'b0;
    chk_cnt++; if (count[2] !== 8'd3) $display("FAIL sat_load: got %0d want 3", count[2]); else pass_cnt++;
    incr[2] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_cnt++;
      if (count[2] !== 8'd3) $display("FAIL sat_hold step%0d: got %0d want 3", i, count[2]); else pass_cnt++;
      chk_cnt++;
      if (tc[2] !== 1'b1) $display("FAIL sat_tc step%0d: got %b want 1", i, tc[2]); else pass_cnt++;
    end
    incr[2] = 1'b0; decr[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_cnt++;
      if (count[2] !== exp_c[i]) $display("FAIL down_count step%0d: got %0d want %0d", i, count[2], exp_c[i]);
      else pass_cnt++;
      chk_cnt++;
      if (tc[2] !== exp_t[i]) $display("FAIL down_tc step%0d: got %b want %b", i, tc[2], exp_t[i]);
      else pass_cnt++;
    end
    decr[2] = 1'b0;
    chk_cnt++; if (ovf[2] !== 1'b1) $display("FAIL sat_ovf: got %b want 1", ovf[2]); else pass_cnt++;
  endtask

  task automatic test_load_clamp();
    max[3] = 8'd10; load[3] = 1'b1; load_val[3] = 8'd200; incr[3] = 1'b1; decr[3] = 1'b1;
    step();
    load[3] = 1'b0;
    chk_cnt++; if (count[3] !== 8'd10) $display("FAIL clamp_count: got %0d want 10", count[3]); else pass_cnt++;
    chk_cnt++; if (tc[3] !== 1'b0)     $display("FAIL clamp_tc: got %b want 0", tc[3]);        else pass_cnt++;
    step();
    incr[3] = 1'b0; decr[3] = 1'b0;
    chk_cnt++; if (count[3] !== 8'd10) $display("FAIL incdec_hold: got %0d want 10", count[3]); else pass_cnt++;
    chk_cnt++; if (tc[3] !== 1'b0)     $display("FAIL incdec_tc: got %b want 0", tc[3]);        else pass_cnt++;
    chk_cnt++; if (ovf[3] !== 1'b0)    $display("FAIL load_ovf: got %b want 0", ovf[3]);        else pass_cnt++;
  endtask

  task automatic test_max_below();
    // ch3 sits at 10; lower its max under the count.
    max[3] = 8'd4; sat = 1'b1; decr[3] = 1'b1;
    step();
    decr[3] = 1'b0;
    chk_cnt++; if (count[3] !== 8'd9) $display("FAIL below_decr: got %0d want 9", count[3]); else pass_cnt++;
    chk_cnt++; if (tc[3] !== 1'b0)    $display("FAIL below_decr_tc: got %b want 0", tc[3]);  else pass_cnt++;
    incr[3] = 1'b1;
    step();
    incr[3] = 1'b0;
    chk_cnt++; if (count[3] !== 8'd4) $display("FAIL below_incr: got %0d want 4", count[3]); else pass_cnt++;
    chk_cnt++; if (tc[3] !== 1'b1)    $display("FAIL below_incr_tc: got %b want 1", tc[3]);  else pass_cnt++;
    chk_cnt++; if (ovf[3] !== 1'b1)   $display("FAIL below_ovf: got %b want 1", ovf[3]);     else pass_cnt++;
  endtask

  task automatic test_max_zero();
    // ch1 sits at 1 after the wrap test.
    max[1] = 8'd0; sat = 1'b0; incr[1] = 1'b1;
    step();
    incr[1] = 1'b0;
    chk_cnt++; if (count[1] !== 8'd0) $display("FAIL zero_incr: got %0d want 0", count[1]); else pass_cnt++;
    chk_cnt++; if (tc[1] !== 1'b1)    $display("FAIL zero_incr_tc: got %b want 1", tc[1]);  else pass_cnt++;
    decr[1] = 1'b1;
    step();
    decr[1] = 1'b0;
    chk_cnt++; if (count[1] !== 8'd0) $display("FAIL zero_decr: got %0d want 0", count[1]); else pass_cnt++;
    chk_cnt++; if (tc[1] !== 1'b1)    $display("FAIL zero_decr_tc: got %b want 1", tc[1]);  else pass_cnt++;
    step();
    chk_cnt++; if (tc[1] !== 1'b0)    $display("FAIL zero_idle_tc: got %b want 0", tc[1]);  else pass_cnt++;
  endtask

  task automatic test_ovf_race();
    // ch0 sits at 5 with ovf clear.
    max[0] = 8'd5; sat = 1'b0; incr[0] = 1'b1; clr_ovf[0] = 1'b1;
    step();
    incr[0] = 1'b0;
    chk_cnt++; if (ovf[0] !== 1'b1)   $display("FAIL race_ovf: got %b want 1", ovf[0]);     else pass_cnt++;
    chk_cnt++; if (count[0] !== 8'd0) $display("FAIL race_count: got %0d want 0", count[0]); else pass_cnt++;
    chk_cnt++; if (tc[0] !== 1'b1)    $display("FAIL race_tc: got %b want 1", tc[0]);       else pass_cnt++;
    step();
    clr_ovf[0] = 1'b0;
    chk_cnt++; if (ovf[0] !== 1'b0)   $display("FAIL clr_ovf: got %b want 0", ovf[0]);      else pass_cnt++;
    chk_cnt++; if (ovf[2] !== 1'b1)   $display("FAIL clr_isolate: got %b want 1", ovf[2]);  else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < CH; i++) max[i] = 8'd255;
    sat = 1'b0; decr = '0; load = '0; clr_ovf = '0; incr = '1;
    step();
    step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cnt++; if (count !== '0) $display("FAIL async_count: got %h want 0", count); else pass_cnt++;
    chk_cnt++; if (ovf !== '0)   $display("FAIL async_ovf: got %b want 0", ovf);     else pass_cnt++;
    chk_cnt++; if (tc !== '0)    $display("FAIL async_tc: got %b want 0", tc);       else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int i = 0; i < CH; i++) begin
      chk_cnt++;
      if (count[i] !== 8'd1) $display("FAIL resume_ch%0d: got %0d want 1", i, count[i]);
      else pass_cnt++;
    end
    incr = '0;
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_sat_down();
    test_load_clamp();
    test_max_below();
    test_max_zero();
    test_ovf_race();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
